// File: rtl/bsg_manycore_endpoint_fc_if.sv
// Handshake and bus bundle for bsg_manycore_endpoint_fc. Signal suffixes are
// from the endpoint's point of view: the endpoint uses the slave modport.
interface bsg_manycore_endpoint_fc_if
  #(parameter int x_cord_width_p = 5
   ,parameter int y_cord_width_p = 5
   ,parameter int addr_width_p   = 32
   ,parameter int data_width_p   = 32
   );

  localparam int packet_width_lp     = 2 + addr_width_p + data_width_p
                                       + 2 * (x_cord_width_p + y_cord_width_p);
  localparam int ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p;

  // requests from the router
  logic                           link_v_i;
  logic [packet_width_lp-1:0]     link_data_i;
  logic                           link_ready_o;

  // requests to the router
  logic                           link_v_o;
  logic [packet_width_lp-1:0]     link_data_o;
  logic                           link_ready_i;

  // return packets from the return router
  logic                           ret_v_i;
  logic [ret_packet_width_lp-1:0] ret_data_i;
  logic                           ret_ready_o;

  // return packets to the return router
  logic                           ret_v_o;
  logic [ret_packet_width_lp-1:0] ret_data_o;
  logic                           ret_ready_i;

  // processor side
  logic                           in_v_o;
  logic [packet_width_lp-1:0]     in_data_o;
  logic                           in_yumi_i;
  logic                           out_v_i;
  logic [packet_width_lp-1:0]     out_data_i;
  logic                           out_ready_o;

  modport slave
    (input  link_v_i, link_data_i, output link_ready_o
    ,output link_v_o, link_data_o, input  link_ready_i
    ,input  ret_v_i,  ret_data_i,  output ret_ready_o
    ,output ret_v_o,  ret_data_o,  input  ret_ready_i
    ,output in_v_o,   in_data_o,   input  in_yumi_i
    ,input  out_v_i,  out_data_i,  output out_ready_o
    );

  modport master
    (output link_v_i, link_data_i, input  link_ready_o
    ,input  link_v_o, link_data_o, output link_ready_i
    ,output ret_v_i,  ret_data_i,  input  ret_ready_o
    ,input  ret_v_o,  ret_data_o,  output ret_ready_i
    ,input  in_v_o,   in_data_o,   output in_yumi_i
    ,output out_v_i,  out_data_i,  input  out_ready_o
    );

endinterface

// File: rtl/bsg_manycore_endpoint_fc.sv
// Credit-flow-controlled manycore endpoint: inbound FIFO, store-ack return slot,
// outbound credit counter and fence FSM. Optional checks: BSG_MANYCORE_ENDPOINT_ERR_CHECK_EN.
module bsg_manycore_endpoint_fc
  #(parameter int x_cord_width_p    = 5
   ,parameter int y_cord_width_p    = 5
   ,parameter int addr_width_p      = 32
   ,parameter int data_width_p      = 32
   ,parameter int fifo_els_p        = 4
   ,parameter int max_out_credits_p = 16
   ,localparam int packet_width_lp     = 2 + addr_width_p + data_width_p
                                         + 2 * (x_cord_width_p + y_cord_width_p)
   ,localparam int ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p
   ,localparam int credit_width_lp     = $clog2(max_out_credits_p + 1)
   )
  (input  logic                       clk_i
  ,input  logic                       reset_n_i
  ,bsg_manycore_endpoint_fc_if.slave  bus
  ,input  logic                       fence_i
  ,output logic                       fence_busy_o
  ,output logic [credit_width_lp-1:0] out_credits_o
  ,input  logic [x_cord_width_p-1:0]  my_x_i
  ,input  logic [y_cord_width_p-1:0]  my_y_i
  ,output logic                       error_o
  );

  localparam int ptr_width_lp   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int count_width_lp = $clog2(fifo_els_p + 1);
  localparam int cord_width_lp  = x_cord_width_p + y_cord_width_p;

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
  localparam logic [count_width_lp-1:0]  fifo_full_lp   = count_width_lp'(fifo_els_p);
  localparam logic [ptr_width_lp-1:0]    ptr_last_lp    = ptr_width_lp'(fifo_els_p - 1);

  typedef enum logic [0:0] {IDLE, DRAIN} state_e;

  // ---------------------------------------------------------------- inbound FIFO
  logic [packet_width_lp-1:0] mem_q [fifo_els_p];
  logic [packet_width_lp-1:0] mem_d [fifo_els_p];
  logic [ptr_width_lp-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [count_width_lp-1:0]  count_q, count_d;
  logic                       full, empty, enq, deq;
  logic [packet_width_lp-1:0] head;
  logic                       head_is_store;

  logic                           ret_full_q, ret_full_d;
  logic [ret_packet_width_lp-1:0] ret_data_q, ret_data_d;

  always_comb begin
    full          = (count_q == fifo_full_lp);
    empty         = (count_q == '0);
    head          = mem_q[rd_ptr_q];
    head_is_store = (head[packet_width_lp-1 -: 2] != 2'd1);
    enq           = bus.link_v_i & ~full;
    deq           = bus.in_yumi_i & ~empty & ~ret_full_q;

    bus.link_ready_o = ~full;
    bus.in_v_o       = ~empty & ~ret_full_q;
    bus.in_data_o    = head;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = bus.link_data_i;
      wr_ptr_d        = (wr_ptr_q == ptr_last_lp) ? '0 : wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == ptr_last_lp) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------- return slot
  // Ack destination is the popped request's source, so {src_y, src_x} maps
  // straight onto {dst_y, dst_x} of the return packet.
  always_comb begin
    ret_full_d = ret_full_q;
    ret_data_d = ret_data_q;
    if (ret_full_q & bus.ret_ready_i) ret_full_d = 1'b0;
    if (deq & head_is_store) begin
      ret_full_d = 1'b1;
      ret_data_d = {5'd0, head[cord_width_lp +: cord_width_lp]};
    end
    bus.ret_v_o    = ret_full_q;
    bus.ret_data_o = ret_data_q;
  end

  // ---------------------------------------------------------------- credits / fence FSM
  state_e                     state_q, state_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic                       started_q, started_d;
  logic                       out_en, accept;

  always_comb begin
    started_d = 1'b1;
    accept    = bus.link_v_o & bus.link_ready_i;
    credits_d = credits_q;
    if (bus.ret_v_i & ~accept & (credits_q != max_credits_lp)) credits_d = credits_q + 1'b1;
    else if (accept & ~bus.ret_v_i)                              credits_d = credits_q - 1'b1;
  end

  // Leaving DRAIN looks at the next credit value so busy drops one cycle after the last return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fence_i & (credits_q != max_credits_lp)) state_d = DRAIN;
      DRAIN:   if (credits_d == max_credits_lp)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_en           = started_q & (credits_q != '0) & (state_q == IDLE);
    bus.link_v_o     = bus.out_v_i & out_en;
    bus.out_ready_o  = bus.link_ready_i & out_en;
    bus.link_data_o  = bus.out_data_i;
    bus.ret_ready_o  = 1'b1;
    fence_busy_o     = (state_q == DRAIN);
    out_credits_o    = credits_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < fifo_els_p; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ret_full_q <= 1'b0;
      ret_data_q <= '0;
      state_q    <= IDLE;
      credits_q  <= max_credits_lp;
      started_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ret_full_q <= ret_full_d;
      ret_data_q <= ret_data_d;
      state_q    <= state_d;
      credits_q  <= credits_d;
      started_q  <= started_d;
    end
  end

  // ---------------------------------------------------------------- protocol checks
`ifdef BSG_MANYCORE_ENDPOINT_ERR_CHECK_EN
  logic error_q, error_d, err_event;

  always_comb begin
    err_event = (bus.ret_v_i & (credits_q == max_credits_lp))
              | (bus.in_yumi_i & ~bus.in_v_o)
              | (bus.link_v_i & full)
              | (enq & bus.link_data_i[packet_width_lp-1]);
    error_d   = error_q | err_event;
    error_o   = error_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_q <= 1'b0;
    else            error_q <= error_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && err_event) $error("bsg_manycore_endpoint_fc: protocol error");
  end
`endif
`else
  always_comb error_o = 1'b0;
`endif

  // Coordinates and return-packet contents do not affect crediting.
  logic unused_inputs;
  always_comb unused_inputs = ^{my_x_i, my_y_i, bus.ret_data_i};

endmodule
